// File: rtl/dma_write_master.sv
// dma_write_master: AXI4 write-channel master draining a FWFT FIFO into memory in 4 KB-safe INCR bursts
//
// Ports:
//   clk, reset_n                            clock, asynchronous active-low reset
//   i_start, i_dst_addr, i_total_len        transfer request (word-aligned byte address, byte count)
//   i_fifo_data, i_fifo_empty, o_fifo_pop   first-word-fall-through source FIFO
//   o_busy, o_write_done, o_write_err       busy level, completion pulse, sticky non-OKAY BRESP flag
//   m_axi_aw*, m_axi_w*, m_axi_b*           AXI4 write address, data and response channels
//
// Build option:
//   DMA_WR_ERR_ABORT_EN  when defined, a non-OKAY BRESP ends the transfer after the current burst.
module dma_write_master #(
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
    input  logic [31:0]                     i_total_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_fifo_data,
    input  logic                            i_fifo_empty,
    output logic                            o_fifo_pop,
    output logic                            o_busy,
    output logic                            o_write_done,
    output logic                            o_write_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d, nxt_addr;
    logic [30:0]                   rem_q, rem_d, nxt_rem;
    logic [1:0]                    tail_q, tail_d;
    logic [8:0]                    beats_q, beats_d, cnt_q, cnt_d;
    logic [7:0]                    awlen_q, awlen_d;
    logic                          awvalid_q, awvalid_d, bready_q, bready_d;
    logic                          err_q, err_d, zero_q, zero_d;
    logic                          in_w, final_beat;

    // Beats for the next burst: limited by what is left, the burst cap and the room before the 4 KB line.
    function automatic logic [8:0] burst_beats(input logic [11:0] a, input logic [30:0] r);
        logic [10:0] cap;
        cap = 11'((13'd4096 - {1'b0, a}) >> 2);
        cap = (cap < 11'(C_M_AXI_BURST_LEN)) ? cap : 11'(C_M_AXI_BURST_LEN);
        return ({20'd0, cap} < r) ? cap[8:0] : r[8:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        tail_d   = tail_q;
        beats_d  = beats_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        zero_d   = zero_q;
        nxt_addr = addr_q + C_M_AXI_ADDR_WIDTH'({beats_q, 2'b00});
        nxt_rem  = rem_q - 31'(beats_q);
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_dst_addr;
                    rem_d   = {1'b0, i_total_len[31:2]} + 31'(|i_total_len[1:0]);
                    tail_d  = i_total_len[1:0];
                    beats_d = burst_beats(i_dst_addr[11:0], rem_d);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    // A zero-length request spends one extra DONE cycle so its pulse lands two cycles after start.
                    zero_d  = (i_total_len == 32'd0);
                    state_d = zero_d ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                if (m_axi_awready) state_d = S_W;
            end
            S_W: begin
                if (m_axi_wvalid && m_axi_wready) begin
                    cnt_d = cnt_q + 9'd1;
                    if (m_axi_wlast) state_d = S_B;
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) err_d = 1'b1;
                    addr_d  = nxt_addr;
                    rem_d   = nxt_rem;
                    cnt_d   = '0;
                    beats_d = burst_beats(nxt_addr[11:0], nxt_rem);
`ifdef DMA_WR_ERR_ABORT_EN
                    state_d = (nxt_rem != '0 && m_axi_bresp == 2'b00) ? S_AW : S_DONE;
`else
                    state_d = (nxt_rem != '0) ? S_AW : S_DONE;
`endif
                end
            end
            S_DONE: begin
                zero_d  = 1'b0;
                state_d = zero_q ? S_DONE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        awvalid_d = (state_d == S_AW);
        bready_d  = (state_d == S_B);
        awlen_d   = (state_d == S_AW) ? 8'(beats_d - 9'd1) : awlen_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            tail_q    <= '0;
            beats_q   <= '0;
            cnt_q     <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            err_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            tail_q    <= tail_d;
            beats_q   <= beats_d;
            cnt_q     <= cnt_d;
            awlen_q   <= awlen_d;
            awvalid_q <= awvalid_d;
            bready_q  <= bready_d;
            err_q     <= err_d;
            zero_q    <= zero_d;
        end
    end

    assign in_w          = (state_q == S_W);
    // The last beat of the last burst carries the partial-word strobe.
    assign final_beat    = m_axi_wlast && (rem_q == 31'(beats_q));
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = in_w && !i_fifo_empty;
    assign m_axi_wdata   = in_w ? i_fifo_data : '0;
    assign m_axi_wlast   = in_w && (cnt_q == beats_q - 9'd1);
    assign m_axi_wstrb   = !in_w ? 4'h0 :
                           (!final_beat || tail_q == 2'd0) ? 4'hF :
                           (tail_q == 2'd1) ? 4'h1 :
                           (tail_q == 2'd2) ? 4'h3 : 4'h7;
    assign m_axi_bready  = bready_q;
    assign o_fifo_pop    = m_axi_wvalid && m_axi_wready;
    assign o_write_done  = (state_q == S_DONE) && !zero_q;
    assign o_busy        = (state_q != S_IDLE) && !o_write_done;
    assign o_write_err   = err_q;
endmodule

// File: tb/tb_dma_write_master.sv
// tb_dma_write_master: table-driven scoreboard bench for dma_write_master
module tb_dma_write_master;
    localparam int BL = 16;
`ifdef DMA_WR_ERR_ABORT_EN
    localparam int ERR_BURSTS = 1;
    localparam int ERR_BEATS  = 16;
`else
    localparam int ERR_BURSTS = 2;
    localparam int ERR_BEATS  = 32;
`endif

    typedef struct {
        logic [31:0] dst;
        logic [31:0] len;
        logic [1:0]  resp0;
        int          bursts;
        int          beats;
        logic        err;
    } vec_t;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_dst_addr = '0;
    logic [31:0] i_total_len = '0;
    logic [31:0] i_fifo_data;
    logic        i_fifo_empty;
    logic        o_fifo_pop, o_busy, o_write_done, o_write_err;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b1;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid;
    logic        m_axi_wready = 1'b1;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    logic [31:0] fifo_q[$];
    logic [1:0]  resp_q[$];
    logic [31:0] fifo_head = '0;
    int          fifo_cnt = 0;
    logic        force_empty = 1'b0;
    int          errors = 0, checks = 0;
    int          aw_cnt = 0, pop_cnt = 0, b_pend = 0;
    vec_t        vecs[9];

    assign i_fifo_data  = fifo_head;
    assign i_fifo_empty = (fifo_cnt == 0) || force_empty;

    always #5 clk = ~clk;

    dma_write_master #(.C_M_AXI_BURST_LEN(BL)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_dst_addr(i_dst_addr),
        .i_total_len(i_total_len), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
        .o_fifo_pop(o_fifo_pop), .o_busy(o_busy), .o_write_done(o_write_done), .o_write_err(o_write_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_cnt  = fifo_q.size();
        fifo_head = (fifo_cnt != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_awaddr"}, m_axi_awaddr, 32'h0);
        check({tag, "_awlen"}, m_axi_awlen, 8'h0);
        check({tag, "_awsize"}, m_axi_awsize, 3'b010);
        check({tag, "_awburst"}, m_axi_awburst, 2'b01);
        check({tag, "_awvalid"}, m_axi_awvalid, 0);
        check({tag, "_wdata"}, m_axi_wdata, 32'h0);
        check({tag, "_wstrb"}, m_axi_wstrb, 4'h0);
        check({tag, "_wlast"}, m_axi_wlast, 0);
        check({tag, "_wvalid"}, m_axi_wvalid, 0);
        check({tag, "_bready"}, m_axi_bready, 0);
        check({tag, "_pop"}, o_fifo_pop, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_write_done, 0);
        check({tag, "_err"}, o_write_err, 0);
    endtask

    // AXI slave, FIFO model and scoreboard: handshakes are judged at the negedge before the edge that takes them.
    initial begin
        logic aw_hs, w_hs, b_hs;
        aw_t  a;
        w_t   w;
        forever begin
            @(negedge clk);
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            if (aw_hs) begin
                if (exp_aw.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL aw_extra: AW addr 0x%0h len %0d issued, none expected", m_axi_awaddr, m_axi_awlen);
                end else begin
                    a = exp_aw.pop_front();
                    check("awaddr", m_axi_awaddr, a.addr);
                    check("awlen", m_axi_awlen, a.len);
                    check("awsize", m_axi_awsize, 3'b010);
                    check("awburst", m_axi_awburst, 2'b01);
                end
            end
            if (w_hs) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_extra: W beat 0x%0h issued, none expected", m_axi_wdata);
                end else begin
                    w = exp_w.pop_front();
                    check("wdata", m_axi_wdata, w.data);
                    check("wstrb", m_axi_wstrb, w.strb);
                    check("wlast", m_axi_wlast, w.last);
                    check("fifo_pop", o_fifo_pop, 1);
                end
                if (m_axi_wlast) b_pend++;
            end else if (o_fifo_pop) begin
                checks++;
                errors++;
                $display("FAIL pop_without_hs: o_fifo_pop=1, expected 0");
            end
            @(posedge clk);
            #1;
            if (aw_hs) aw_cnt++;
            if (w_hs) begin
                pop_cnt++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (b_hs) m_axi_bvalid = 1'b0;
            if (!m_axi_bvalid && b_pend > 0) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                b_pend--;
            end
            fifo_refresh();
        end
    end

    // Reference model: split the request into bursts and queue the AW/W beats it must produce.
    task automatic prep(input vec_t v, input int idx);
        longint a, r, b, room;
        int     n;
        bit     first;
        exp_aw.delete();
        exp_w.delete();
        resp_q.delete();
        fifo_q.delete();
        a = longint'(v.dst);
        r = (longint'(v.len) + 3) / 4;
        n = 0;
        first = 1'b1;
        for (longint k = 0; k < r; k++) fifo_q.push_back(32'((idx << 8) + k));
        while (r > 0) begin
            room = (4096 - (a % 4096)) / 4;
            b = (r < BL) ? r : BL;
            if (room < b) b = room;
            exp_aw.push_back('{addr: 32'(a), len: 8'(b - 1)});
            for (longint i = 0; i < b; i++) begin
                logic [3:0] strb;
                strb = (i == b - 1 && r == b && v.len[1:0] != 2'd0) ? 4'((1 << v.len[1:0]) - 1) : 4'hF;
                exp_w.push_back('{data: 32'((idx << 8) + n), strb: strb, last: (i == b - 1)});
                n++;
            end
            resp_q.push_back(first ? v.resp0 : 2'b00);
`ifdef DMA_WR_ERR_ABORT_EN
            if (first && v.resp0 != 2'b00) break;
`endif
            a = a + 4 * b;
            r = r - b;
            first = 1'b0;
        end
        aw_cnt  = 0;
        pop_cnt = 0;
        fifo_refresh();
    endtask

    task automatic launch(input vec_t v);
        tick();
        i_dst_addr  = v.dst;
        i_total_len = v.len;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        @(negedge clk);
        check("awvalid_after_start", m_axi_awvalid, v.len != 0);
        check("busy_after_start", o_busy, 1);
    endtask

    task automatic finish_check(input vec_t v, input bit start_on_done);
        int t;
        t = 1;
        while (!o_write_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", o_write_done, 1);
        if (v.len == 0) check("zero_len_done_cycle", t, 2);
        check("busy_in_done", o_busy, 0);
        check("bursts", aw_cnt, v.bursts);
        check("pops", pop_cnt, v.beats);
        check("err", o_write_err, v.err);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
        if (start_on_done) begin
            i_dst_addr  = 32'h7000;
            i_total_len = 32'd64;
            i_start     = 1'b1;
        end
        tick();
        i_start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", o_write_done, 0);
        check("idle_busy", o_busy, 0);
        check("idle_awvalid", m_axi_awvalid, 0);
    endtask

    task automatic run_vector(input vec_t v, input int idx, input bit start_on_done);
        prep(v, idx);
        launch(v);
        finish_check(v, start_on_done);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   t;
        int   p0;
        vecs[0] = '{32'h0000_1000, 32'd64,  2'b00, 1, 16, 1'b0};
        vecs[1] = '{32'h0000_2000, 32'd72,  2'b00, 2, 18, 1'b0};
        vecs[2] = '{32'h0000_0FF8, 32'd32,  2'b00, 2, 8,  1'b0};
        vecs[3] = '{32'h0000_3000, 32'd6,   2'b00, 1, 2,  1'b0};
        vecs[4] = '{32'h0000_3100, 32'd0,   2'b00, 0, 0,  1'b0};
        vecs[5] = '{32'h0000_4000, 32'd128, 2'b10, ERR_BURSTS, ERR_BEATS, 1'b1};
        vecs[6] = '{32'h0000_0FFC, 32'd5,   2'b00, 2, 2,  1'b0};
        vecs[7] = '{32'h0000_5000, 32'd300, 2'b00, 5, 75, 1'b0};
        vecs[8] = '{32'h0000_7FE0, 32'd128, 2'b00, 3, 32, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst_init");
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vector(vecs[i], i, i == 3);

        // AW held under backpressure, start ignored while busy, FIFO empty and wready stalls mid-burst.
        v = '{32'h0000_5000, 32'd64, 2'b00, 1, 16, 1'b0};
        prep(v, 10);
        m_axi_awready = 1'b0;
        launch(v);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_hold_valid", m_axi_awvalid, 1);
            check("aw_hold_addr", m_axi_awaddr, 32'h5000);
            check("aw_hold_len", m_axi_awlen, 8'd15);
        end
        tick();
        m_axi_awready = 1'b1;
        tick();
        i_dst_addr  = 32'h9000;
        i_total_len = 32'd8;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        t = 0;
        while (pop_cnt < 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reach_pop4", pop_cnt >= 4, 1);
        tick();
        force_empty = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("empty_wvalid", m_axi_wvalid, 0);
            check("empty_pop", o_fifo_pop, 0);
        end
        tick();
        check("empty_pop_count", pop_cnt, p0);
        force_empty   = 1'b0;
        m_axi_wready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_wvalid", m_axi_wvalid, 1);
            check("stall_pop", o_fifo_pop, 0);
            check("stall_wdata", m_axi_wdata, exp_w[0].data);
            check("stall_wstrb", m_axi_wstrb, exp_w[0].strb);
        end
        tick();
        m_axi_wready = 1'b1;
        @(negedge clk);
        finish_check(v, 1'b0);

        // Asynchronous reset in the middle of a W burst.
        v = '{32'h0000_6000, 32'd64, 2'b00, 1, 16, 1'b0};
        prep(v, 11);
        launch(v);
        t = 0;
        while (pop_cnt < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reach_pop3", pop_cnt >= 3, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset("rst_mid");
        exp_aw.delete();
        exp_w.delete();
        resp_q.delete();
        fifo_q.delete();
        b_pend = 0;
        m_axi_bvalid = 1'b0;
        fifo_refresh();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        run_vector(vecs[0], 12, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
